// File: rtl/hangman_ctrl_param_if.sv
// Handshake bundle between the hangman game controller and its environment.
// The parameters must match those of the hangman_ctrl_param instance it connects to.
interface hangman_ctrl_param_if #(
  parameter int MAX_LEN    = 16,
  parameter int MISS_LIMIT = 10,
  parameter int SCORE_W    = 4,
  parameter int TURN_TICKS = 30
);
  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int PART_W = $clog2(MISS_LIMIT + 1);
  localparam int TIME_W = $clog2(TURN_TICKS + 1);

  logic              load;
  logic              end_input;
  logic              start;
  logic              try_guess;
  logic              wipe;
  logic              tick;
  logic              match;
  logic [LEN_W-1:0]  match_count;

  logic              ld;
  logic              ld_graph;
  logic              timecount;
  logic              compare;
  logic              fill;
  logic              draw;
  logic              over;
  logic              win;
  logic [LEN_W-1:0]  word_len;
  logic [LEN_W-1:0]  remain;
  logic [PART_W-1:0] part;
  logic [TIME_W-1:0] time_left;
  logic [SCORE_W-1:0] p1score;
  logic [SCORE_W-1:0] p2score;

  modport master (
    output load, end_input, start, try_guess, wipe, tick, match, match_count,
    input  ld, ld_graph, timecount, compare, fill, draw, over, win,
    input  word_len, remain, part, time_left, p1score, p2score
  );

  modport slave (
    input  load, end_input, start, try_guess, wipe, tick, match, match_count,
    output ld, ld_graph, timecount, compare, fill, draw, over, win,
    output word_len, remain, part, time_left, p1score, p2score
  );
endinterface

// File: rtl/hangman_ctrl_param.sv
// Parametrised two-player hangman game controller with saturating scores.
// The per-turn guess timeout is enabled only when HANGMAN_TIMEOUT_EN is defined.
module hangman_ctrl_param #(
  parameter int MAX_LEN    = 16,
  parameter int MISS_LIMIT = 10,
  parameter int SCORE_W    = 4,
  parameter int TURN_TICKS = 30
) (
  input  logic clk,
  input  logic resetn,
  hangman_ctrl_param_if.slave bus
);
  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int PART_W = $clog2(MISS_LIMIT + 1);
  localparam int TIME_W = $clog2(TURN_TICKS + 1);

  localparam logic [LEN_W-1:0]   LEN_MAX   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);
  localparam logic [PART_W-1:0]  PART_ONE  = PART_W'(1);
  localparam logic [PART_W-1:0]  PART_LAST = PART_W'(MISS_LIMIT - 1);
  localparam logic [TIME_W-1:0]  TIME_MAX  = TIME_W'(TURN_TICKS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [3:0] {
    S_LOAD       = 4'd0,
    S_LOAD_WAIT  = 4'd1,
    S_GRAPH      = 4'd2,
    S_WAIT_GUESS = 4'd3,
    S_COMPARE    = 4'd4,
    S_EVAL       = 4'd5,
    S_FILL       = 4'd6,
    S_DRAW       = 4'd7,
    S_WIN        = 4'd8,
    S_LOSE       = 4'd9
  } state_e;

  typedef struct packed {
    logic ld;
    logic ld_graph;
    logic timecount;
    logic compare;
    logic fill;
    logic draw;
    logic over;
    logic win;
  } strobes_t;

  function automatic strobes_t decode(input state_e s);
    strobes_t o;
    o = '0;
    case (s)
      S_LOAD:       o.ld        = 1'b1;
      S_GRAPH:      o.ld_graph  = 1'b1;
      S_WAIT_GUESS: o.timecount = 1'b1;
      S_COMPARE:    o.compare   = 1'b1;
      S_FILL:       o.fill      = 1'b1;
      S_DRAW:       o.draw      = 1'b1;
      S_WIN: begin
        o.over = 1'b1;
        o.win  = 1'b1;
      end
      S_LOSE:       o.over      = 1'b1;
      default:      o           = '0;
    endcase
    return o;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == SCORE_MAX) ? v : v + SCORE_W'(1);
  endfunction

  state_e             state_q, state_d;
  strobes_t           strobes_q;
  logic               load_prev_q;
  logic [LEN_W-1:0]   word_len_q, word_len_d;
  logic [LEN_W-1:0]   remain_q, remain_d;
  logic [LEN_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [PART_W-1:0]  part_q, part_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic [SCORE_W-1:0] p1_q, p1_d;
  logic [SCORE_W-1:0] p2_q, p2_d;
  logic               load_rise_s;
  logic               timeout_s;

`ifdef HANGMAN_TIMEOUT_EN
  localparam logic [TIME_W-1:0] TIME_ONE = TIME_W'(1);
`else
  logic unused_tick_s;
  assign unused_tick_s = bus.tick;
`endif

  // Next-state and counter update logic for the game FSM.
  always_comb begin
    state_d     = state_q;
    word_len_d  = word_len_q;
    remain_d    = remain_q;
    fill_cnt_d  = fill_cnt_q;
    part_d      = part_q;
    time_d      = time_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    load_rise_s = bus.load & ~load_prev_q;
`ifdef HANGMAN_TIMEOUT_EN
    // A tick that empties the timer times out in the same cycle, ahead of any guess.
    timeout_s   = (time_q == '0) || (bus.tick && (time_q == TIME_ONE));
`else
    timeout_s   = 1'b0;
`endif

    case (state_q)
      S_LOAD: begin
        if (load_rise_s && (word_len_q != LEN_MAX)) begin
          word_len_d = word_len_q + LEN_ONE;
          state_d    = S_LOAD_WAIT;
        end else if (bus.end_input && (word_len_q != '0)) begin
          remain_d = word_len_q;
          part_d   = '0;
          state_d  = S_GRAPH;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD_WAIT: begin
        if (!bus.load) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_LOAD_WAIT;
        end
      end
      S_GRAPH: begin
        if (bus.start) begin
          time_d  = TIME_MAX;
          state_d = S_WAIT_GUESS;
        end else begin
          state_d = S_GRAPH;
        end
      end
      S_WAIT_GUESS: begin
        if (timeout_s) begin
          p1_d    = sat_inc(p1_q);
          state_d = S_LOSE;
        end else if (bus.try_guess) begin
          state_d = S_COMPARE;
        end else begin
          state_d = S_WAIT_GUESS;
        end
`ifdef HANGMAN_TIMEOUT_EN
        if (bus.tick && (time_q != '0)) begin
          time_d = time_q - TIME_ONE;
        end else begin
          time_d = time_q;
        end
`endif
      end
      S_COMPARE: state_d = S_EVAL;
      S_EVAL: begin
        if (bus.match && (bus.match_count != '0)) begin
          fill_cnt_d = (bus.match_count > remain_q) ? remain_q : bus.match_count;
          state_d    = S_FILL;
        end else begin
          state_d = S_DRAW;
        end
      end
      S_FILL: begin
        remain_d   = remain_q - LEN_ONE;
        fill_cnt_d = fill_cnt_q - LEN_ONE;
        if (remain_q == LEN_ONE) begin
          p2_d    = sat_inc(p2_q);
          state_d = S_WIN;
        end else if (fill_cnt_q == LEN_ONE) begin
          time_d  = TIME_MAX;
          state_d = S_WAIT_GUESS;
        end else begin
          state_d = S_FILL;
        end
      end
      S_DRAW: begin
        part_d = part_q + PART_ONE;
        if (part_q == PART_LAST) begin
          p1_d    = sat_inc(p1_q);
          state_d = S_LOSE;
        end else begin
          time_d  = TIME_MAX;
          state_d = S_WAIT_GUESS;
        end
      end
      S_WIN, S_LOSE: begin
        if (bus.wipe) begin
          word_len_d = '0;
          remain_d   = '0;
          fill_cnt_d = '0;
          part_d     = '0;
          time_d     = '0;
          state_d    = S_LOAD;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State, counters, scores and strobes; strobes follow the next state so they align with state_q.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_LOAD;
      strobes_q   <= '0;
      load_prev_q <= 1'b0;
      word_len_q  <= '0;
      remain_q    <= '0;
      fill_cnt_q  <= '0;
      part_q      <= '0;
      time_q      <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
    end else begin
      state_q     <= state_d;
      strobes_q   <= decode(state_d);
      load_prev_q <= bus.load;
      word_len_q  <= word_len_d;
      remain_q    <= remain_d;
      fill_cnt_q  <= fill_cnt_d;
      part_q      <= part_d;
      time_q      <= time_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
    end
  end

  assign bus.ld        = strobes_q.ld;
  assign bus.ld_graph  = strobes_q.ld_graph;
  assign bus.timecount = strobes_q.timecount;
  assign bus.compare   = strobes_q.compare;
  assign bus.fill      = strobes_q.fill;
  assign bus.draw      = strobes_q.draw;
  assign bus.over      = strobes_q.over;
  assign bus.win       = strobes_q.win;
  assign bus.word_len  = word_len_q;
  assign bus.remain    = remain_q;
  assign bus.part      = part_q;
  assign bus.time_left = time_q;
  assign bus.p1score   = p1_q;
  assign bus.p2score   = p2_q;
endmodule

// File: tb/tb_hangman_ctrl_param.sv
// Directed self-checking bench for hangman_ctrl_param (MAX_LEN=16, MISS_LIMIT=10, SCORE_W=4, TURN_TICKS=3).
// Timeout checks follow HANGMAN_TIMEOUT_EN when it is defined for the build.
module tb_hangman_ctrl_param;
  logic clk;
  logic resetn;
  int   tests;
  int   fails;

  hangman_ctrl_param_if #(.MAX_LEN(16), .MISS_LIMIT(10), .SCORE_W(4), .TURN_TICKS(3)) bus ();

  hangman_ctrl_param #(.MAX_LEN(16), .MISS_LIMIT(10), .SCORE_W(4), .TURN_TICKS(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pulse();
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    step();
  endtask

  task automatic end_in();
    bus.end_input = 1'b1;
    step();
    bus.end_input = 1'b0;
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic do_wipe();
    bus.wipe = 1'b1;
    step();
    bus.wipe = 1'b0;
  endtask

  task automatic tick_pulse();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    step();
  endtask

  // Guess presented for one cycle; returns three cycles later in the fill/draw state.
  task automatic do_guess(input logic hit, input logic [4:0] cnt);
    bus.try_guess = 1'b1;
    step();
    check("compare_pulse", {31'd0, bus.compare}, 32'd1);
    bus.try_guess = 1'b0;
    step();
    bus.match       = hit;
    bus.match_count = cnt;
    step();
    bus.match       = 1'b0;
    bus.match_count = 5'd0;
  endtask

  task automatic count_fill(output int n);
    n = 0;
    while ((bus.fill === 1'b1) && (n < 40)) begin
      n++;
      step();
    end
  endtask

  int nfill;
  int ndraw;
  int nextra;

  initial begin
    tests = 0;
    fails = 0;
    resetn = 1'b0;
    bus.load = 1'b0;
    bus.end_input = 1'b0;
    bus.start = 1'b0;
    bus.try_guess = 1'b0;
    bus.wipe = 1'b0;
    bus.tick = 1'b0;
    bus.match = 1'b0;
    bus.match_count = 5'd0;

    step();
    step();
    check("rst_strobes", {24'd0, bus.ld, bus.ld_graph, bus.timecount, bus.compare,
                          bus.fill, bus.draw, bus.over, bus.win}, 32'd0);
    check("rst_word_len", {27'd0, bus.word_len}, 32'd0);
    check("rst_scores", {24'd0, bus.p1score, bus.p2score}, 32'd0);
    resetn = 1'b1;
    step();
    check("load_ld", {31'd0, bus.ld}, 32'd1);

    // Empty word cannot be committed.
    end_in();
    check("empty_end_ld", {31'd0, bus.ld}, 32'd1);
    check("empty_end_graph", {31'd0, bus.ld_graph}, 32'd0);

    for (int i = 0; i < 5; i++) load_pulse();
    check("word_len5", {27'd0, bus.word_len}, 32'd5);
    end_in();
    check("graph_ld_graph", {31'd0, bus.ld_graph}, 32'd1);
    check("graph_remain", {27'd0, bus.remain}, 32'd5);
    check("graph_part", {28'd0, bus.part}, 32'd0);
    start_game();
    check("wait_timecount", {31'd0, bus.timecount}, 32'd1);
    check("wait_time_left", {30'd0, bus.time_left}, 32'd3);

    do_guess(1'b1, 5'd2);
    count_fill(nfill);
    check("fill2_cycles", nfill, 32'd2);
    check("fill2_remain", {27'd0, bus.remain}, 32'd3);
    check("fill2_back_wait", {31'd0, bus.timecount}, 32'd1);

    // Overshooting match count is clipped to the remaining characters.
    do_guess(1'b1, 5'd7);
    count_fill(nfill);
    check("fill_clip_cycles", nfill, 32'd3);
    check("win_flags", {30'd0, bus.over, bus.win}, 32'd3);
    check("win_remain", {27'd0, bus.remain}, 32'd0);
    check("win_p2score", {28'd0, bus.p2score}, 32'd1);
    do_wipe();
    check("wipe_ld", {31'd0, bus.ld}, 32'd1);
    check("wipe_word_len", {27'd0, bus.word_len}, 32'd0);
    check("wipe_p2_kept", {28'd0, bus.p2score}, 32'd1);

    for (int i = 0; i < 17; i++) load_pulse();
    check("word_len_sat", {27'd0, bus.word_len}, 32'd16);
    end_in();
    start_game();
    ndraw = 0;
    nextra = 0;
    for (int i = 0; i < 10; i++) begin
      do_guess((i == 4) ? 1'b1 : 1'b0, 5'd0);
      ndraw += int'(bus.draw);
      step();
      nextra += int'(bus.draw);
    end
    check("miss_draws", ndraw, 32'd10);
    check("miss_draw_width", nextra, 32'd0);
    check("miss_part", {28'd0, bus.part}, 32'd10);
    check("lose_flags", {30'd0, bus.over, bus.win}, 32'd2);
    check("lose_p1score", {28'd0, bus.p1score}, 32'd1);
    do_wipe();

    for (int i = 0; i < 15; i++) begin
      load_pulse();
      end_in();
      start_game();
      do_guess(1'b1, 5'd1);
      step();
      check("quick_win", {31'd0, bus.win}, 32'd1);
      do_wipe();
    end
    check("p2score_sat", {28'd0, bus.p2score}, 32'd15);

    load_pulse();
    end_in();
    start_game();
    for (int i = 0; i < 3; i++) tick_pulse();
`ifdef HANGMAN_TIMEOUT_EN
    check("timeout_lose", {30'd0, bus.over, bus.win}, 32'd2);
    check("timeout_p1score", {28'd0, bus.p1score}, 32'd2);
    do_wipe();
    load_pulse();
    end_in();
    start_game();
    tick_pulse();
    tick_pulse();
    check("time_left_one", {30'd0, bus.time_left}, 32'd1);
    bus.tick = 1'b1;
    bus.try_guess = 1'b1;
    step();
    bus.tick = 1'b0;
    bus.try_guess = 1'b0;
    check("timeout_beats_guess", {30'd0, bus.compare, bus.over}, 32'd1);
    check("timeout2_p1score", {28'd0, bus.p1score}, 32'd3);
    do_wipe();
`else
    check("no_timeout_time", {30'd0, bus.time_left}, 32'd3);
    check("no_timeout_wait", {30'd0, bus.timecount, bus.over}, 32'd2);
    bus.tick = 1'b1;
    bus.try_guess = 1'b1;
    step();
    bus.tick = 1'b0;
    bus.try_guess = 1'b0;
    check("no_timeout_compare", {31'd0, bus.compare}, 32'd1);
    step();
    step();
    check("no_timeout_draw", {31'd0, bus.draw}, 32'd1);
    step();
    check("no_timeout_part", {28'd0, bus.part}, 32'd1);
    do_guess(1'b1, 5'd1);
    step();
    check("p2score_hold", {28'd0, bus.p2score}, 32'd15);
    do_wipe();
`endif

    // Asynchronous reset in the middle of a fill burst.
    for (int i = 0; i < 3; i++) load_pulse();
    end_in();
    start_game();
    do_guess(1'b1, 5'd2);
    check("pre_reset_fill", {31'd0, bus.fill}, 32'd1);
    resetn = 1'b0;
    #1;
    check("async_rst_strobes", {24'd0, bus.ld, bus.ld_graph, bus.timecount, bus.compare,
                                bus.fill, bus.draw, bus.over, bus.win}, 32'd0);
    check("async_rst_counts", {16'd0, bus.word_len, bus.remain, bus.part, bus.time_left}, 32'd0);
    check("async_rst_scores", {24'd0, bus.p1score, bus.p2score}, 32'd0);
    resetn = 1'b1;
    step();
    check("post_rst_ld", {31'd0, bus.ld}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hangman_ctrl_param.md
Name: hangman_ctrl_param

Overview:
Parametrised game controller for the two-player hangman design, next generation of the fixed-size control FSM. Player 1 loads a secret word of up to MAX_LEN characters. Player 2 then guesses against it, with a configurable miss limit and a per-turn guess timer. The block drives the datapath strobes (load, compare, fill, draw) and keeps saturating scores for both players across rounds.

Parameters:
MAX_LEN, 16, maximum secret-word length in characters; LEN_W = $clog2(MAX_LEN+1)
MISS_LIMIT, 10, number of hangman parts drawn before player 2 loses; PART_W = $clog2(MISS_LIMIT+1)
SCORE_W, 4, width of each score counter
TURN_TICKS, 30, tick pulses allowed per guess before timeout; TIME_W = $clog2(TURN_TICKS+1)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
load  in  1  level; player 1 is entering a character
end_input  in  1  pulse; the secret word is complete
start  in  1  pulse; begin the guessing phase
try_guess  in  1  pulse; a guess character is presented
wipe  in  1  pulse; restart the round after win/lose
tick  in  1  one-cycle timebase pulse (e.g. 1 Hz)
match  in  1  datapath comparator result, valid in the cycle after compare
match_count  in  LEN_W  number of positions matched, valid with match
ld  out  1  datapath loads a secret character
ld_graph  out  1  draw the base graphic
timecount  out  1  turn timer running
compare  out  1  datapath compares the guess
fill  out  1  datapath reveals one matched position
draw  out  1  draw the next hangman part
over  out  1  round finished
win  out  1  player 2 won the round
word_len  out  LEN_W  characters loaded
remain  out  LEN_W  unrevealed characters
part  out  PART_W  parts drawn
time_left  out  TIME_W  ticks remaining this turn
p1score  out  SCORE_W  player 1 score
p2score  out  SCORE_W  player 2 score

Behaviour:
- Reset (async, resetn=0): state=S_LOAD; every counter and score = 0; all strobes = 0.
- State-decoded (Moore) outputs, one state register; other state lives in registered counters.
- S_LOAD: ld=1.
  - Rising edge of load with word_len<MAX_LEN → word_len++, go to S_LOAD_WAIT.
  - load edge at word_len==MAX_LEN is ignored.
  - end_input with word_len>0 → remain=word_len, part=0, go to S_GRAPH.
  - end_input with word_len==0 is ignored.
  - If load and end_input arrive together, load wins.
- S_LOAD_WAIT: stay while load=1; return to S_LOAD when load=0.
- S_GRAPH: ld_graph=1; start → S_WAIT_GUESS with time_left=TURN_TICKS.
- S_WAIT_GUESS: timecount=1.
  - Each tick decrements time_left.
  - try_guess → S_COMPARE.
  - time_left==0 → S_LOSE. Timeout beats try_guess in the same cycle.
- S_COMPARE: compare=1 for exactly one cycle → S_EVAL.
- S_EVAL: samples match/match_count.
  - match=1 and match_count>0 → load fill_cnt=min(match_count, remain), go to S_FILL.
  - Otherwise (miss) → S_DRAW.
- S_FILL: fill=1 for exactly fill_cnt cycles; remain decrements each cycle.
  - remain reaches 0 → S_WIN.
  - Otherwise → S_WAIT_GUESS with time_left reloaded.
- S_DRAW: draw=1 for one cycle; part++.
  - part reaches MISS_LIMIT → S_LOSE.
  - Otherwise → S_WAIT_GUESS with time_left reloaded.
- S_WIN: over=1, win=1. p2score increments once on entry. wipe → S_LOAD.
- S_LOSE: over=1, win=0. p1score increments once on entry. wipe → S_LOAD.
- Leaving S_WIN/S_LOSE on wipe clears word_len, remain, part and time_left. Scores persist.
- Scores saturate at 2^SCORE_W-1; they never wrap.
- Latency: try_guess to first fill/draw strobe is 3 cycles.
- Illegal state encoding → S_LOAD.

Optional Feature:
HANGMAN_TIMEOUT_EN:
- Defined: turn timer behaves as above.
- Undefined: time_left is held at TURN_TICKS, tick is ignored and timeout never occurs. timecount is still asserted in S_WAIT_GUESS.

Test Plan:
- Load 5 chars (5 load pulses), end_input → word_len=5, remain=5, ld_graph=1 in S_GRAPH.
- After start, guess with match=1, match_count=2 → fill high 2 cycles, remain=3; further guesses revealing 3 more → win=1, p2score=1.
- MISS_LIMIT=10: 10 consecutive misses → 10 single-cycle draw pulses, part=10, over=1, win=0, p1score=1.
- TURN_TICKS=3: 3 ticks in S_WAIT_GUESS with no guess → S_LOSE. tick and try_guess in the same cycle that time_left reaches 0 → S_LOSE, no compare pulse.
- Boundaries: 17 load pulses with MAX_LEN=16 → word_len=16; end_input at word_len=0 ignored; match_count=7 with remain=3 → exactly 3 fill cycles; 16 wins with SCORE_W=4 → p2score=15.
- Assert resetn low during S_FILL → all outputs 0 immediately, state S_LOAD; wipe restarts with scores retained.
